// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS channel decoder: control tokens,
// alignment FSM states, bit-offset type and the token lookup.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOK_00 = 10'h354;
    localparam logic [9:0] CTRL_TOK_01 = 10'h0AB;
    localparam logic [9:0] CTRL_TOK_10 = 10'h154;
    localparam logic [9:0] CTRL_TOK_11 = 10'h2AB;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef logic [3:0] offset_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] ctrl;
    } ctrl_hit_t;

    // Map a 10-bit symbol to {hit, C1C0}; non-tokens return hit=0, ctrl=00.
    function automatic ctrl_hit_t is_ctrl_token(input logic [9:0] sym);
        ctrl_hit_t r;
        r.hit  = 1'b1;
        r.ctrl = 2'b00;
        case (sym)
            CTRL_TOK_00: r.ctrl = 2'b00;
            CTRL_TOK_01: r.ctrl = 2'b01;
            CTRL_TOK_10: r.ctrl = 2'b10;
            CTRL_TOK_11: r.ctrl = 2'b11;
            default: begin
                r.hit  = 1'b0;
                r.ctrl = 2'b00;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational TMDS word decoder: one aligned 10-bit symbol to control
// flag/pair and the 8-bit data value it would carry as a data symbol.
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    ctrl_hit_t  tok;
    logic [7:0] d;

    // Token lookup plus inverse of the transmitter's XOR/XNOR chain.
    always_comb begin
        tok     = is_ctrl_token(sym);
        is_ctrl = tok.hit;
        ctrl    = tok.ctrl;
        d       = sym[9] ? ~sym[7:0] : sym[7:0];
        data    = '0;
        data[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: hunts for the word boundary using runs of control
// tokens, holds lock while tokens keep appearing, and decodes symbols.
//
// state  | meaning
// SEARCH | no alignment; looking for a token at the current offset
// CHECK  | token seen; counting consecutive tokens towards lock
// LOCKED | alignment found; decoding, watching for token starvation
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN_MIN   = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic       pi_clk,
    input  logic       pi_rst,
    input  logic [9:0] pi_sym,
    input  logic       pi_resync,
    output logic [7:0] po_data,
    output logic [1:0] po_ctrl,
    output logic       po_de,
    output logic       po_locked,
    output logic [3:0] po_offset
);

    localparam int RUN_W  = (CTRL_RUN_MIN   > 1) ? $clog2(CTRL_RUN_MIN)   : 1;
    localparam int TMO_W  = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
    localparam int LOSS_W = (LOSS_TIMEOUT   > 1) ? $clog2(LOSS_TIMEOUT)   : 1;

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_RUN_MIN - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

    logic [9:0]        r0, r1, win;
    logic [19:0]       hist;
    state_t            state, state_nxt;
    offset_t           offset, offset_nxt, offset_slip;
    logic [RUN_W-1:0]  run_cnt, run_nxt;
    logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
    logic [LOSS_W-1:0] loss_cnt, loss_nxt;
    logic              tok_hit, out_en;
    logic [1:0]        tok_ctrl;
    logic [7:0]        dec_data;

    // Two-symbol history; r1 is older, so its bits come first in time.
    always_ff @(posedge pi_clk or negedge pi_rst) begin
        if (!pi_rst) begin
            r0 <= '0;
            r1 <= '0;
        end else begin
            r0 <= pi_sym;
            r1 <= r0;
        end
    end

    assign hist        = {r0, r1};
    assign win         = 10'(hist >> offset);
    assign offset_slip = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
    assign po_offset   = offset;

    tmds_word_decode u_word (
        .sym     (win),
        .is_ctrl (tok_hit),
        .ctrl    (tok_ctrl),
        .data    (dec_data)
    );

    // State register with alignment counters.
    always_ff @(posedge pi_clk or negedge pi_rst) begin
        if (!pi_rst) begin
            state    <= SEARCH;
            offset   <= '0;
            run_cnt  <= '0;
            tmo_cnt  <= '0;
            loss_cnt <= '0;
        end else begin
            state    <= state_nxt;
            offset   <= offset_nxt;
            run_cnt  <= run_nxt;
            tmo_cnt  <= tmo_nxt;
            loss_cnt <= loss_nxt;
        end
    end

    // Next-state: resync first, then a completing lock run beats the search timeout.
    always_comb begin
        state_nxt  = state;
        offset_nxt = offset;
        run_nxt    = run_cnt;
        tmo_nxt    = tmo_cnt;
        loss_nxt   = loss_cnt;
        if (pi_resync) begin
            state_nxt  = SEARCH;
            offset_nxt = offset_slip;
            run_nxt    = '0;
            tmo_nxt    = '0;
            loss_nxt   = '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (tmo_cnt == TMO_LAST) begin
                        offset_nxt = offset_slip;
                        tmo_nxt    = '0;
                        run_nxt    = '0;
                    end else begin
                        tmo_nxt = tmo_cnt + TMO_W'(1);
                        if (tok_hit) begin
                            state_nxt = CHECK;
                            run_nxt   = RUN_W'(1);
                        end
                    end
                end
                CHECK: begin
                    if (tok_hit && run_cnt == RUN_LAST) begin
                        state_nxt = LOCKED;
                        run_nxt   = '0;
                        tmo_nxt   = '0;
                        loss_nxt  = '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state_nxt  = SEARCH;
                        offset_nxt = offset_slip;
                        tmo_nxt    = '0;
                        run_nxt    = '0;
                    end else begin
                        tmo_nxt = tmo_cnt + TMO_W'(1);
                        if (tok_hit) begin
                            run_nxt = run_cnt + RUN_W'(1);
                        end else begin
                            state_nxt = SEARCH;
                            run_nxt   = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (tok_hit) begin
                        loss_nxt = '0;
                    end else if (loss_cnt == LOSS_LAST) begin
                        state_nxt = SEARCH;
                        loss_nxt  = '0;
                        tmo_nxt   = '0;
                    end else begin
                        loss_nxt = loss_cnt + LOSS_W'(1);
                    end
                end
                default: begin
                    state_nxt = SEARCH;
                end
            endcase
        end
    end

    // Outputs: decode only on cycles that stay locked, so the symbol that
    // ends lock (starvation or resync) is never presented with po_de=1.
    always_comb begin
        po_locked = (state == LOCKED);
        out_en    = (state == LOCKED) && (state_nxt == LOCKED);
    end

    // Output registers: data and control each hold until their own symbol kind arrives.
    always_ff @(posedge pi_clk or negedge pi_rst) begin
        if (!pi_rst) begin
            po_data <= '0;
            po_ctrl <= '0;
            po_de   <= 1'b0;
        end else begin
            po_de <= out_en && !tok_hit;
            if (out_en) begin
                if (tok_hit) begin
                    po_ctrl <= tok_ctrl;
                end else begin
                    po_data <= dec_data;
                end
            end
        end
    end

endmodule
